// File: rtl/nios_sopc_gpio_edge_if.sv
// rtl/nios_sopc_gpio_edge_if.sv - Avalon-MM slave bus bundle for the GPIO edge block
//
// Signals:
//   address    [2:0]  word address of the register being accessed
//   chipselect        slave select, qualifies write_n
//   write_n           active-low write strobe
//   writedata  [31:0] write data from the interconnect
//   readdata   [31:0] registered read data back to the interconnect
interface nios_sopc_gpio_edge_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_sopc_gpio_edge.sv
// rtl/nios_sopc_gpio_edge.sv - Avalon-MM GPIO slave with direction, set/clear and edge-capture IRQ
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     synchronous active-high reset
//   bus       Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   gpio_in   asynchronous pin inputs, WIDTH bits
//   gpio_out  output data register, WIDTH bits
//   gpio_oe   per-bit output enable (1 = drive the pin)
//   irq       level interrupt, high while any unmasked captured edge is pending
module nios_sopc_gpio_edge #(
    parameter int               WIDTH     = 8,
    parameter int               EDGE_TYPE = 0,
    parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    nios_sopc_gpio_edge_if.slave       bus,
    input  logic [WIDTH-1:0]           gpio_in,
    output logic [WIDTH-1:0]           gpio_out,
    output logic [WIDTH-1:0]           gpio_oe,
    output logic                       irq
);
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_edge_det;
    logic [WIDTH-1:0] w_edge_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[WIDTH-1:0];

    // Upper writedata bits beyond WIDTH carry nothing for this block.
    assign w_unused_wdata = ^bus.writedata;

    generate
        if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge_det = ~r_sync2 & r_prev;
        end else if (EDGE_TYPE == 2) begin : g_edge_any
            assign w_edge_det = r_sync2 ^ r_prev;
        end else begin : g_edge_rise
            assign w_edge_det = r_sync2 & ~r_prev;
        end
    endgenerate

    assign w_edge_clr = (w_wr && bus.address == ADDR_EDGECAP) ? w_wdata : '0;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= RESET_OUT;
            r_dir  <= '0;
            r_mask <= '0;
            r_edge <= '0;
        end else begin
            if (w_wr) begin
                case (bus.address)
                    ADDR_DATA:     r_out  <= w_wdata;
                    ADDR_DIR:      r_dir  <= w_wdata;
                    ADDR_IRQMASK:  r_mask <= w_wdata;
                    ADDR_OUTSET:   r_out  <= r_out | w_wdata;
                    ADDR_OUTCLEAR: r_out  <= r_out & ~w_wdata;
                    default:       ;
                endcase
            end
            // OR-ing the new edges after the clear makes a same-cycle edge win.
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_det;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    w_rd_mux[WIDTH-1:0] = r_sync2;
            ADDR_DIR:     w_rd_mux[WIDTH-1:0] = r_dir;
            ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_mask;
            ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edge;
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign gpio_out     = r_out;
    assign gpio_oe      = r_dir;
    assign irq          = |(r_edge & r_mask);
endmodule

// File: tb/tb_nios_sopc_gpio_edge.sv
// tb/tb_nios_sopc_gpio_edge.sv - self-checking bench for nios_sopc_gpio_edge
module tb_nios_sopc_gpio_edge;
    localparam int         EDGE_T = 0;
    localparam logic [7:0] RST_OUT = 8'hA5;

    logic       clk;
    logic       reset;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       irq;

    int checks;
    int errors;

    // Reference state: registers by their software-visible meaning, pins as a sample history.
    logic [7:0]  m_out;
    logic [7:0]  m_dir;
    logic [7:0]  m_mask;
    logic [7:0]  m_edge;
    logic [31:0] m_rd;
    logic [7:0]  pin_q[$];

    nios_sopc_gpio_edge_if bus_if ();

    nios_sopc_gpio_edge #(
        .WIDTH     (8),
        .EDGE_TYPE (EDGE_T),
        .RESET_OUT (RST_OUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pin_q holds the last three sampled pin values, oldest first:
    // [0] is what the block sees as "previous", [1] as the synchronised value.
    task automatic model_step();
        logic [7:0] s2;
        logic [7:0] pv;
        logic [7:0] det;
        logic [7:0] clr;
        logic [7:0] wd;
        if (reset) begin
            m_out  = RST_OUT;
            m_dir  = 8'h00;
            m_mask = 8'h00;
            m_edge = 8'h00;
            m_rd   = 32'h0;
            pin_q  = '{8'h00, 8'h00, 8'h00};
        end else begin
            pv = pin_q[0];
            s2 = pin_q[1];
            case (EDGE_T)
                1:       det = ~s2 & pv;
                2:       det = s2 ^ pv;
                default: det = s2 & ~pv;
            endcase
            case (bus_if.address)
                3'd0:    m_rd = {24'h0, s2};
                3'd1:    m_rd = {24'h0, m_dir};
                3'd2:    m_rd = {24'h0, m_mask};
                3'd3:    m_rd = {24'h0, m_edge};
                default: m_rd = 32'h0;
            endcase
            clr = 8'h00;
            wd  = bus_if.writedata[7:0];
            if (bus_if.chipselect && !bus_if.write_n) begin
                case (bus_if.address)
                    3'd0:    m_out = wd;
                    3'd1:    m_dir = wd;
                    3'd2:    m_mask = wd;
                    3'd3:    clr = wd;
                    3'd4:    m_out = m_out | wd;
                    3'd5:    m_out = m_out & ~wd;
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~clr) | det;
            pin_q.push_back(gpio_in);
            void'(pin_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        bus_if.address    = a;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        gpio_in = 8'h00;
        idle(2);
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL reset_gpio_out got %h want a5", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL reset_gpio_oe got %h want 00", gpio_oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
        checks++; if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", bus_if.readdata); end
        reset = 1'b0;
    endtask

    task automatic test_dir_out();
        bus_write(3'd1, 32'h0F);
        checks++; if (gpio_oe !== 8'h0F) begin errors++; $display("FAIL dir_oe got %h want 0f", gpio_oe); end
        bus_write(3'd0, 32'h3C);
        checks++; if (gpio_out !== 8'h3C) begin errors++; $display("FAIL data_out got %h want 3c", gpio_out); end
        bus_write(3'd4, 32'h40);
        checks++; if (gpio_out !== 8'h7C) begin errors++; $display("FAIL outset got %h want 7c", gpio_out); end
        bus_write(3'd5, 32'h04);
        checks++; if (gpio_out !== 8'h78) begin errors++; $display("FAIL outclear got %h want 78", gpio_out); end
    endtask

    task automatic test_input_sync();
        bus_if.address = 3'd0;
        gpio_in = 8'h81;
        idle(2);
        checks++; if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL sync_early got %h want 0", bus_if.readdata); end
        tick();
        checks++; if (bus_if.readdata !== 32'h81) begin errors++; $display("FAIL sync_read got %h want 81", bus_if.readdata); end
    endtask

    task automatic test_rising_irq();
        gpio_in = 8'h02;
        idle(4);
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h01);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", irq); end
        gpio_in = 8'h03;
        idle(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_too_early got %b want 0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", irq); end
        bus_read(3'd3);
        checks++; if (bus_if.readdata !== 32'h01) begin errors++; $display("FAIL edgecap_rise got %h want 01", bus_if.readdata); end
        gpio_in = 8'h01;
        idle(4);
        bus_read(3'd3);
        checks++; if (bus_if.readdata !== 32'h01) begin errors++; $display("FAIL edgecap_fall got %h want 01", bus_if.readdata); end
    endtask

    task automatic test_clear_vs_edge();
        gpio_in = 8'h00;
        idle(4);
        gpio_in = 8'h01;
        idle(2);
        bus_write(3'd3, 32'h01);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b want 1", irq); end
        bus_read(3'd3);
        checks++; if (bus_if.readdata !== 32'h01) begin errors++; $display("FAIL set_wins_cap got %h want 01", bus_if.readdata); end
        bus_write(3'd3, 32'h01);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clear_irq got %b want 0", irq); end
    endtask

    task automatic test_mask_reserved();
        bus_write(3'd2, 32'h00);
        gpio_in = 8'h05;
        idle(4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got %b want 0", irq); end
        bus_read(3'd3);
        checks++; if (bus_if.readdata !== 32'h04) begin errors++; $display("FAIL masked_cap got %h want 04", bus_if.readdata); end
        bus_write(3'd2, 32'h04);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq got %b want 1", irq); end
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_write(3'd7, 32'h0000_0000);
        checks++; if (gpio_out !== 8'h78) begin errors++; $display("FAIL rsvd_out got %h want 78", gpio_out); end
        checks++; if (gpio_oe !== 8'h0F) begin errors++; $display("FAIL rsvd_oe got %h want 0f", gpio_oe); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rsvd_irq got %b want 1", irq); end
        bus_read(3'd2);
        checks++; if (bus_if.readdata !== 32'h04) begin errors++; $display("FAIL rsvd_mask got %h want 04", bus_if.readdata); end
        for (int a = 4; a < 8; a++) begin
            bus_read(3'(a));
            checks++; if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL read_zero addr %0d got %h want 0", a, bus_if.readdata); end
        end
    endtask

    task automatic test_random();
        logic [48:0] got;
        logic [48:0] want;
        for (int i = 0; i < 600; i++) begin
            reset             = ($urandom_range(0, 59) == 0);
            bus_if.address    = 3'($urandom_range(0, 7));
            bus_if.chipselect = 1'($urandom_range(0, 1));
            bus_if.write_n    = 1'($urandom_range(0, 1));
            bus_if.writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) gpio_in = 8'($urandom);
            tick();
            got  = {gpio_out, gpio_oe, irq, bus_if.readdata};
            want = {m_out, m_dir, |(m_edge & m_mask), m_rd};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random cycle %0d got out=%h oe=%h irq=%b rd=%h want out=%h oe=%h irq=%b rd=%h",
                         i, gpio_out, gpio_oe, irq, bus_if.readdata, m_out, m_dir, |(m_edge & m_mask), m_rd);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        reset             = 1'b1;
        gpio_in           = 8'h00;
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;
        pin_q             = '{8'h00, 8'h00, 8'h00};
        m_out             = RST_OUT;
        m_dir             = 8'h00;
        m_mask            = 8'h00;
        m_edge            = 8'h00;
        m_rd              = 32'h0;

        test_reset();
        test_dir_out();
        test_input_sync();
        test_rising_irq();
        test_clear_vs_edge();
        test_mask_reserved();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
